// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RISC-V front end.
package riscv_pkg;

   localparam int INSTR_W  = 32;
   localparam int PC_STEP  = 4;
   localparam int PC_MAX_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   // One buffered fetch result; pc is held at full width and narrowed by users.
   typedef struct packed {
      logic [INSTR_W-1:0]  instr;
      logic [PC_MAX_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched (instr, pc) pairs with flush.
module fetch_buf
   import riscv_pkg::*;
#(
   parameter logic [PC_MAX_W-1:0] RESET_ENTRY_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output fetch_entry_t head,
   output logic [1:0]   occ
);

   localparam fetch_entry_t RESET_ENTRY = {NOP_INSTR, RESET_ENTRY_PC};

   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic         do_push;
   logic         do_pop;

   // Pops need something to remove and pushes need room unless a pop frees a slot.
   always_comb begin
      do_pop  = pop & (occ != 2'd0);
      do_push = push & ((occ != 2'd2) | do_pop);
   end

   // Slot 0 is always the head; a pop shifts slot 1 forward so order is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0 <= RESET_ENTRY;
         slot1 <= RESET_ENTRY;
         occ   <= 2'd0;
      end else if (flush) begin
         occ <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= push_entry;
               else             slot1 <= push_entry;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= push_entry;
               end else begin
                  slot0 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = slot0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues reads to a 1-cycle synchronous memory,
// buffers returned words and hands (instr, pc) pairs to decode.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter int unsigned RESET_PC = 0,
   parameter int          ADDR_W   = 11
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_rd_addr,
   output logic              imem_rd_en,
   input  logic [31:0]       imem_rd_instr,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] issue_addr;
   logic              issue;
   logic              issue_seq;
   logic [2:0]        pending;
   logic              pop;
   logic              push;
   logic [1:0]        occ;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;
   logic              unused_pc_hi;

   assign redirect_addr = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign out_valid     = (occ != 2'd0);
   assign pop           = out_valid & out_ready;
   assign push          = inflight & ~redirect_valid;

   // Pick this cycle's request: redirect wins, otherwise sequential if room remains.
   always_comb begin
      pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      issue_seq  = fetch_en & (pending < 3'd2);
      issue      = 1'b0;
      issue_addr = pc;
      if (!rst) begin
         if (redirect_valid) begin
            issue      = 1'b1;
            issue_addr = redirect_addr;
         end else begin
            issue      = issue_seq;
            issue_addr = pc;
         end
      end
   end

   assign imem_rd_en   = issue;
   assign imem_rd_addr = issue_addr;

   // Track the next sequential address and the address whose data returns next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_ADDR;
         inflight    <= 1'b0;
         inflight_pc <= RESET_ADDR;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= issue_addr;
            pc          <= issue_addr + ADDR_W'(PC_STEP);
         end
      end
   end

   assign push_entry = '{instr: imem_rd_instr, pc: PC_MAX_W'(inflight_pc)};

   fetch_buf #(
      .RESET_ENTRY_PC (PC_MAX_W'(RESET_ADDR))
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .head       (head),
      .occ        (occ)
   );

   assign out_instr    = head.instr;
   assign out_pc       = head.pc[ADDR_W-1:0];
   assign unused_pc_hi = ^head.pc[PC_MAX_W-1:ADDR_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run checked against a stream-level model of what decode should receive.
module tb_instr_fetch;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en, redirect_valid, out_ready;
   logic [10:0] redirect_pc;
   logic [10:0] imem_rd_addr, out_pc;
   logic        imem_rd_en, out_valid;
   logic [31:0] imem_rd_instr, out_instr;

   logic [10:0] imem_rd_addr2, out_pc2;
   logic        imem_rd_en2, out_valid2;
   logic [31:0] imem_rd_instr2, out_instr2;
   logic        fetch_en2 = 1'b1;
   logic        out_ready2 = 1'b1;
   logic        redirect_valid2 = 1'b0;
   logic [10:0] redirect_pc2 = 11'h0;

   int n_compared = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(0), .ADDR_W(11)) dut (
      .clk(clk), .rst(rst), .imem_rd_addr(imem_rd_addr), .imem_rd_en(imem_rd_en),
      .imem_rd_instr(imem_rd_instr), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   instr_fetch #(.RESET_PC(32'h7F8), .ADDR_W(11)) dut_wrap (
      .clk(clk), .rst(rst), .imem_rd_addr(imem_rd_addr2), .imem_rd_en(imem_rd_en2),
      .imem_rd_instr(imem_rd_instr2), .fetch_en(fetch_en2), .redirect_valid(redirect_valid2),
      .redirect_pc(redirect_pc2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_instr(out_instr2), .out_pc(out_pc2)
   );

   function automatic logic [31:0] word_at(input logic [10:0] a);
      return 32'hA000_0000 + {23'b0, a[10:2]};
   endfunction

   // Synchronous memories: word i holds A000_0000+i, data held while not read.
   always @(posedge clk) begin
      if (imem_rd_en)  imem_rd_instr  <= word_at(imem_rd_addr);
      if (imem_rd_en2) imem_rd_instr2 <= word_at(imem_rd_addr2);
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      redirect_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 11'h0;
      #2;
      n_compared++; if (imem_rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_en got %b want 0", imem_rd_en); end
      n_compared++; if (imem_rd_addr !== 11'h0) begin n_mismatched++; $display("[TB] FAIL reset_addr got %h want 000", imem_rd_addr); end
      n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
      n_compared++; if (out_instr !== NOP_INSTR) begin n_mismatched++; $display("[TB] FAIL reset_instr got %h want %h", out_instr, NOP_INSTR); end
      n_compared++; if (out_pc !== 11'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc got %h want 000", out_pc); end
      n_compared++; if (imem_rd_addr2 !== 11'h7F8) begin n_mismatched++; $display("[TB] FAIL reset_addr_wrap got %h want 7f8", imem_rd_addr2); end
      n_compared++; if (out_pc2 !== 11'h7F8) begin n_mismatched++; $display("[TB] FAIL reset_pc_wrap got %h want 7f8", out_pc2); end
   endtask

   task automatic test_startup;
      fetch_en = 1'b1; out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cycle();
         #1;
         n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'(4*c)) begin n_mismatched++; $display("[TB] FAIL startup_req c%0d got en=%b addr=%h want en=1 addr=%h", c, imem_rd_en, imem_rd_addr, 11'(4*c)); end
         n_compared++; if (out_valid !== (c >= 2)) begin n_mismatched++; $display("[TB] FAIL startup_valid c%0d got %b want %b", c, out_valid, (c >= 2)); end
         if (c >= 2) begin
            n_compared++; if (out_pc !== 11'(4*(c-2)) || out_instr !== word_at(11'(4*(c-2)))) begin n_mismatched++; $display("[TB] FAIL startup_out c%0d got pc=%h instr=%h want pc=%h instr=%h", c, out_pc, out_instr, 11'(4*(c-2)), word_at(11'(4*(c-2)))); end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [10:0] want_pc;
      fetch_en = 1'b1; out_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) next_cycle();
         out_ready = (c >= 7);
         #1;
         if (c >= 3 && c <= 6) begin
            n_compared++; if (imem_rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_stall_en c%0d got %b want 0", c, imem_rd_en); end
            n_compared++; if (dut.u_buf.occ !== 2'd2) begin n_mismatched++; $display("[TB] FAIL bp_occ c%0d got %0d want 2", c, dut.u_buf.occ); end
         end
         if (c == 7) begin
            n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'h8) begin n_mismatched++; $display("[TB] FAIL bp_resume got en=%b addr=%h want en=1 addr=008", imem_rd_en, imem_rd_addr); end
         end
         if (c >= 2) begin
            want_pc = (c <= 7) ? 11'h0 : 11'(4*(c-7));
            n_compared++; if (out_valid !== 1'b1 || out_pc !== want_pc || out_instr !== word_at(want_pc)) begin n_mismatched++; $display("[TB] FAIL bp_out c%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, out_valid, out_pc, out_instr, want_pc, word_at(want_pc)); end
         end
      end
   endtask

   task automatic test_redirect;
      fetch_en = 1'b1; out_ready = 1'b0;
      do_reset();
      repeat (4) next_cycle();
      redirect_valid = 1'b1; redirect_pc = 11'h103;
      #1;
      n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'h100) begin n_mismatched++; $display("[TB] FAIL redir_req got en=%b addr=%h want en=1 addr=100", imem_rd_en, imem_rd_addr); end
      next_cycle();
      redirect_valid = 1'b0; out_ready = 1'b1;
      #1;
      n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL redir_flush got valid=%b want 0", out_valid); end
      n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'h104) begin n_mismatched++; $display("[TB] FAIL redir_seq got en=%b addr=%h want en=1 addr=104", imem_rd_en, imem_rd_addr); end
      next_cycle(); #1;
      n_compared++; if (out_valid !== 1'b1 || out_pc !== 11'h100 || out_instr !== word_at(11'h100)) begin n_mismatched++; $display("[TB] FAIL redir_target got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h", out_valid, out_pc, out_instr, word_at(11'h100)); end
      next_cycle(); #1;
      n_compared++; if (out_valid !== 1'b1 || out_pc !== 11'h104) begin n_mismatched++; $display("[TB] FAIL redir_next got v=%b pc=%h want v=1 pc=104", out_valid, out_pc); end
   endtask

   task automatic test_fetch_en;
      fetch_en = 1'b1; out_ready = 1'b1;
      do_reset();
      #1;
      n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'h0) begin n_mismatched++; $display("[TB] FAIL fen_first got en=%b addr=%h want en=1 addr=000", imem_rd_en, imem_rd_addr); end
      for (int c = 1; c < 9; c++) begin
         next_cycle();
         fetch_en = (c >= 6);
         #1;
         if (c <= 5) begin
            n_compared++; if (imem_rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fen_off_en c%0d got %b want 0", c, imem_rd_en); end
         end
         if (c == 2 || c == 8) begin
            n_compared++; if (out_valid !== 1'b1 || out_pc !== ((c == 2) ? 11'h0 : 11'h4)) begin n_mismatched++; $display("[TB] FAIL fen_out c%0d got v=%b pc=%h", c, out_valid, out_pc); end
         end
         if (c == 3 || c == 7) begin
            n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fen_gap c%0d got valid=%b want 0", c, out_valid); end
         end
         if (c == 6) begin
            n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'h4) begin n_mismatched++; $display("[TB] FAIL fen_resume got en=%b addr=%h want en=1 addr=004", imem_rd_en, imem_rd_addr); end
         end
      end
   endtask

   task automatic test_wrap;
      logic [10:0] seq [6];
      seq = '{11'h7F8, 11'h7FC, 11'h000, 11'h004, 11'h008, 11'h00C};
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) next_cycle();
         #1;
         if (c < 4) begin
            n_compared++; if (imem_rd_en2 !== 1'b1 || imem_rd_addr2 !== seq[c]) begin n_mismatched++; $display("[TB] FAIL wrap_req c%0d got en=%b addr=%h want addr=%h", c, imem_rd_en2, imem_rd_addr2, seq[c]); end
         end
         if (c >= 2) begin
            n_compared++; if (out_valid2 !== 1'b1 || out_pc2 !== seq[c-2] || out_instr2 !== word_at(seq[c-2])) begin n_mismatched++; $display("[TB] FAIL wrap_out c%0d got v=%b pc=%h instr=%h want pc=%h", c, out_valid2, out_pc2, out_instr2, seq[c-2]); end
         end
      end
   endtask

   task automatic test_mid_reset;
      fetch_en = 1'b1; out_ready = 1'b1;
      do_reset();
      repeat (5) next_cycle();
      rst = 1'b1;
      #1;
      n_compared++; if (out_valid !== 1'b0 || imem_rd_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_drop got valid=%b en=%b want 0 0", out_valid, imem_rd_en); end
      n_compared++; if (out_pc !== 11'h0 || out_instr !== NOP_INSTR) begin n_mismatched++; $display("[TB] FAIL midrst_head got pc=%h instr=%h want 000 %h", out_pc, out_instr, NOP_INSTR); end
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         #1;
         n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== 11'(4*c)) begin n_mismatched++; $display("[TB] FAIL midrst_req c%0d got en=%b addr=%h want addr=%h", c, imem_rd_en, imem_rd_addr, 11'(4*c)); end
         n_compared++; if (out_valid !== (c >= 2)) begin n_mismatched++; $display("[TB] FAIL midrst_valid c%0d got %b want %b", c, out_valid, (c >= 2)); end
         if (c >= 2) begin
            n_compared++; if (out_pc !== 11'(4*(c-2)) || out_instr !== word_at(11'(4*(c-2)))) begin n_mismatched++; $display("[TB] FAIL midrst_out c%0d got pc=%h instr=%h", c, out_pc, out_instr); end
         end
      end
   endtask

   task automatic test_random;
      logic [10:0] exp_pc, target, held_pc;
      logic [31:0] held_instr;
      bit prev_redir, prev2_redir, hold;
      fetch_en = 1'b1; out_ready = 1'b1;
      do_reset();
      exp_pc = 11'h0; prev_redir = 0; prev2_redir = 0; hold = 0;
      held_pc = 11'h0; held_instr = 32'h0; target = 11'h0;
      for (int i = 0; i < 800; i++) begin
         if (i > 0) next_cycle();
         out_ready = ($urandom_range(0, 3) != 0);
         fetch_en = ($urandom_range(0, 7) != 0);
         redirect_valid = !prev_redir && ($urandom_range(0, 15) == 0);
         redirect_pc = 11'($urandom_range(0, 2047));
         #1;
         if (prev_redir) begin
            n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rnd_flush i%0d got valid=%b want 0", i, out_valid); end
         end
         if (prev2_redir) begin
            n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rnd_target_latency i%0d got valid=%b want 1", i, out_valid); end
         end
         if (hold) begin
            n_compared++; if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin n_mismatched++; $display("[TB] FAIL rnd_hold i%0d got v=%b pc=%h instr=%h want pc=%h instr=%h", i, out_valid, out_pc, out_instr, held_pc, held_instr); end
         end
         if (out_valid && out_ready && !redirect_valid) begin
            n_compared++; if (out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin n_mismatched++; $display("[TB] FAIL rnd_stream i%0d got pc=%h instr=%h want pc=%h instr=%h", i, out_pc, out_instr, exp_pc, word_at(exp_pc)); end
            exp_pc = exp_pc + 11'd4;
         end
         if (redirect_valid) begin
            target = {redirect_pc[10:2], 2'b00};
            n_compared++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== target) begin n_mismatched++; $display("[TB] FAIL rnd_redir_req i%0d got en=%b addr=%h want addr=%h", i, imem_rd_en, imem_rd_addr, target); end
            exp_pc = target;
         end
         hold = out_valid && !out_ready && !redirect_valid;
         held_pc = out_pc;
         held_instr = out_instr;
         prev2_redir = prev_redir;
         prev_redir = redirect_valid;
      end
      redirect_valid = 1'b0;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect();
      test_fetch_en();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
